// File: rtl/alarm_trigger.sv
// Alarm trigger: compares running time with the alarm setting and runs the
// ring/snooze sequence that drives the buzzer, paced by a 1 Hz tick.
module alarm_trigger #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int SNOOZE_MAX  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [3:0] t0,
    input  logic [3:0] t1,
    input  logic [3:0] t2,
    input  logic [3:0] t3,
    input  logic [3:0] al0,
    input  logic [3:0] al1,
    input  logic [3:0] al2,
    input  logic [3:0] al3,
    input  logic       balam,
    input  logic       en,
    input  logic       bsnz,
    input  logic       bstop,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snz_cnt
);

    localparam logic [8:0] LP_RING_SECS   = 9'(RING_SECS);
    localparam logic [8:0] LP_SNOOZE_SECS = 9'(SNOOZE_SECS);
    localparam logic [1:0] LP_SNOOZE_MAX  = 2'(SNOOZE_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [8:0] r_sec_cnt;
    logic [8:0] w_sec_next;
    logic [8:0] w_sec_inc;
    logic       r_phase;
    logic       w_phase_next;
    logic [1:0] r_snz_cnt;
    logic [1:0] w_snz_next;
    logic       r_match_q;
    logic       r_snz_q;
    logic       r_stop_q;
    logic       r_buzzer;
    logic       r_ringing;
    logic       r_snoozing;

    logic w_match;
    logic w_trig;
    logic w_snz_press;
    logic w_stop_press;

    assign w_match      = (t3 == al3) && (t2 == al2) && (t1 == al1) && (t0 == al0);
    assign w_trig       = w_match && !r_match_q && en && !balam;
    assign w_snz_press  = bsnz && !r_snz_q;
    assign w_stop_press = bstop && !r_stop_q;
    assign w_sec_inc    = r_sec_cnt + 9'd1;

    always_comb begin
        w_state_next = r_state;
        w_sec_next   = r_sec_cnt;
        w_phase_next = r_phase;
        w_snz_next   = r_snz_cnt;
        if (!en || balam) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        w_state_next = S_RING;
                        w_sec_next   = 9'd0;
                        w_snz_next   = 2'd0;
                        w_phase_next = 1'b1;
                    end
                end
                S_RING: begin
                    // a press that is acted on swallows a coincident tick
                    if (w_stop_press) begin
                        w_state_next = S_IDLE;
                    end else if (w_snz_press && (r_snz_cnt < LP_SNOOZE_MAX)) begin
                        w_state_next = S_SNOOZE;
                        w_snz_next   = r_snz_cnt + 2'd1;
                        w_sec_next   = 9'd0;
                    end else if (tick) begin
                        w_sec_next   = w_sec_inc;
                        w_phase_next = !r_phase;
                        if (w_sec_inc == LP_RING_SECS) begin
                            w_state_next = S_IDLE;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (w_stop_press) begin
                        w_state_next = S_IDLE;
                    end else if (tick) begin
                        w_sec_next = w_sec_inc;
                        if (w_sec_inc == LP_SNOOZE_SECS) begin
                            w_state_next = S_RING;
                            w_sec_next   = 9'd0;
                            w_phase_next = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sec_cnt  <= 9'd0;
            r_phase    <= 1'b0;
            r_snz_cnt  <= 2'd0;
            r_match_q  <= 1'b0;
            r_snz_q    <= 1'b0;
            r_stop_q   <= 1'b0;
            r_buzzer   <= 1'b0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sec_cnt  <= w_sec_next;
            r_phase    <= w_phase_next;
            r_snz_cnt  <= w_snz_next;
            r_match_q  <= w_match;
            r_snz_q    <= bsnz;
            r_stop_q   <= bstop;
            // outputs follow the next state so the buzzer drops with the state change
            r_buzzer   <= (w_state_next == S_RING) && w_phase_next;
            r_ringing  <= (w_state_next == S_RING);
            r_snoozing <= (w_state_next == S_SNOOZE);
        end
    end

    assign buzzer   = r_buzzer;
    assign ringing  = r_ringing;
    assign snoozing = r_snoozing;
    assign snz_cnt  = r_snz_cnt;

endmodule

// File: tb/tb_alarm_trigger.sv
// Self-checking bench for alarm_trigger: directed scenarios plus a random
// phase, all compared against an event-level model of the alarm behaviour.
module tb_alarm_trigger;

    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;
    localparam int SNOOZE_MAX  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] t0 = 4'd0, t1 = 4'd0, t2 = 4'd0, t3 = 4'd0;
    logic [3:0] al0 = 4'd0, al1 = 4'd0, al2 = 4'd0, al3 = 4'd0;
    logic       balam = 1'b0;
    logic       en = 1'b0;
    logic       bsnz = 1'b0;
    logic       bstop = 1'b0;
    logic       buzzer, ringing, snoozing;
    logic [1:0] snz_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // model: mode 0 = quiet, 1 = ringing, 2 = snoozing
    int m_mode = 0;
    int m_elapsed = 0;
    int m_snz = 0;
    bit m_match_prev = 0, m_snz_prev = 0, m_stop_prev = 0;

    alarm_trigger #(
        .RING_SECS  (RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS),
        .SNOOZE_MAX (SNOOZE_MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .t0      (t0),
        .t1      (t1),
        .t2      (t2),
        .t3      (t3),
        .al0     (al0),
        .al1     (al1),
        .al2     (al2),
        .al3     (al3),
        .balam   (balam),
        .en      (en),
        .bsnz    (bsnz),
        .bstop   (bstop),
        .buzzer  (buzzer),
        .ringing (ringing),
        .snoozing(snoozing),
        .snz_cnt (snz_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = 0;
        m_elapsed = 0;
        m_snz = 0;
        m_match_prev = 0;
        m_snz_prev = 0;
        m_stop_prev = 0;
    endfunction

    function automatic void model_step();
        bit match, trig, sp, tp;
        if (!rst_n) begin
            model_reset();
            return;
        end
        match = (t3 == al3) && (t2 == al2) && (t1 == al1) && (t0 == al0);
        trig  = match && !m_match_prev && en && !balam;
        sp    = bsnz && !m_snz_prev;
        tp    = bstop && !m_stop_prev;
        if (!en || balam) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (trig) begin
                m_mode = 1; m_elapsed = 0; m_snz = 0;
            end
        end else if (tp) begin
            m_mode = 0;
        end else if (m_mode == 1 && sp && m_snz < SNOOZE_MAX) begin
            m_mode = 2; m_snz++; m_elapsed = 0;
        end else if (tick) begin
            m_elapsed++;
            if (m_mode == 1 && m_elapsed == RING_SECS) begin
                m_mode = 0;
            end else if (m_mode == 2 && m_elapsed == SNOOZE_SECS) begin
                m_mode = 1; m_elapsed = 0;
            end
        end
        m_match_prev = match;
        m_snz_prev   = bsnz;
        m_stop_prev  = bstop;
    endfunction

    task automatic chk(input string tag);
        // buzzer sounds on the even-numbered seconds of each ring interval
        logic       e_buz = (m_mode == 1) && (m_elapsed % 2 == 0);
        logic       e_rng = (m_mode == 1);
        logic       e_snz = (m_mode == 2);
        logic [1:0] e_cnt = 2'(m_snz);
        n_cmp++;
        assert (buzzer === e_buz) else begin
            n_bad++;
            $error("FAIL %s buzzer observed=%0b expected=%0b", tag, buzzer, e_buz);
        end
        n_cmp++;
        assert (ringing === e_rng) else begin
            n_bad++;
            $error("FAIL %s ringing observed=%0b expected=%0b", tag, ringing, e_rng);
        end
        n_cmp++;
        assert (snoozing === e_snz) else begin
            n_bad++;
            $error("FAIL %s snoozing observed=%0b expected=%0b", tag, snoozing, e_snz);
        end
        n_cmp++;
        assert (snz_cnt === e_cnt) else begin
            n_bad++;
            $error("FAIL %s snz_cnt observed=%0d expected=%0d", tag, snz_cnt, e_cnt);
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk(tag);
    endtask

    task automatic run_ticks(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) cyc(tag);
            tick = 1'b1;
            cyc(tag);
            tick = 1'b0;
        end
    endtask

    task automatic press_snz(input string tag);
        bsnz = 1'b1;
        cyc(tag);
        bsnz = 1'b0;
        cyc(tag);
    endtask

    task automatic set_min(input logic [3:0] m);
        t0 = m;
    endtask

    initial begin
        // reset asserted asynchronously, outputs checked without a clock edge
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk("reset");
        cyc("reset");
        cyc("reset");
        rst_n = 1'b1;

        // 07:29 -> 07:30, ring then auto-stop after RING_SECS ticks
        al3 = 4'd0; al2 = 4'd7; al1 = 4'd3; al0 = 4'd0;
        t3 = 4'd0; t2 = 4'd7; t1 = 4'd2; t0 = 4'd9;
        en = 1'b1;
        repeat (3) cyc("idle");
        t1 = 4'd3; t0 = 4'd0;
        cyc("latency");
        run_ticks(RING_SECS + 2, "autostop");

        // retrigger, stop together with the 5th tick, no retrigger in same minute
        set_min(4'd1); cyc("retrig");
        set_min(4'd0); cyc("retrig");
        run_ticks(4, "ring");
        tick = 1'b1; bstop = 1'b1;
        cyc("stop_tick");
        tick = 1'b0;
        repeat (10) cyc("no_retrig");
        bstop = 1'b0;
        run_ticks(5, "no_retrig");
        set_min(4'd1); cyc("retrig2");
        set_min(4'd0); cyc("retrig2");

        // snooze three times, the fourth press is ignored
        for (int s = 0; s < SNOOZE_MAX; s++) begin
            run_ticks(3, "ring");
            press_snz("snooze_press");
            run_ticks(SNOOZE_SECS, "snooze_wait");
        end
        run_ticks(2, "ring");
        press_snz("snooze_max");
        run_ticks(3, "snooze_max");

        // snooze and stop rising together: stop wins, count kept
        bsnz = 1'b1; bstop = 1'b1;
        cyc("snz_stop");
        bsnz = 1'b0; bstop = 1'b0;
        cyc("snz_stop");

        // match suppressed by en=0 and by balam=1
        set_min(4'd1); cyc("gate");
        en = 1'b0; set_min(4'd0);
        repeat (3) cyc("en_off");
        en = 1'b1;
        repeat (2) cyc("en_on_same_min");
        set_min(4'd1); balam = 1'b1; cyc("balam");
        set_min(4'd0);
        repeat (3) cyc("balam");
        balam = 1'b0; cyc("balam");

        // drop enable during snooze
        set_min(4'd1); cyc("ring3");
        set_min(4'd0); cyc("ring3");
        press_snz("snooze3");
        run_ticks(5, "snooze3");
        en = 1'b0; cyc("en_drop");
        en = 1'b1; cyc("en_drop");

        // reset mid-ring, then the still-matching time triggers again
        set_min(4'd1); cyc("ring4");
        set_min(4'd0); cyc("ring4");
        run_ticks(7, "ring4");
        rst_n = 1'b0;
        model_reset();
        #1 chk("async_rst");
        cyc("in_rst");
        cyc("in_rst");
        rst_n = 1'b1;
        repeat (4) cyc("post_rst");
        run_ticks(3, "post_rst");

        // random phase: one stimulus change per cycle
        for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 99);
            tick = 1'b0;
            if (r < 45)      tick = 1'b1;
            else if (r < 55) bsnz = ~bsnz;
            else if (r < 58) bstop = ~bstop;
            else if (r < 66) set_min($urandom_range(0, 1) != 0 ? 4'd0 : 4'd1);
            else if (r < 68) en = ($urandom_range(0, 7) != 0);
            else if (r < 70) balam = ($urandom_range(0, 7) == 0);
            cyc("rand");
        end
        tick = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
